// File: rtl/nic2noc_flit_sender.sv
// Injection stage of the NIC transmit path: grants an idle VC per packet, streams
// flits under per-VC credit control and releases the VC pointer once all credits return.
module nic2noc_flit_sender #(
   parameter int N_TOT_OF_VC    = 6,
   parameter int N_BITS_POINTER = 5,
   parameter int BUFFER_DEPTH   = 4,
   parameter int N_BITS_CREDIT  = 3,
   parameter int FLIT_WIDTH     = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  pkt_req_i,
   input  logic [N_BITS_POINTER-1:0]             pkt_buffer_id_i,
   input  logic [N_TOT_OF_VC-1:0]                pkt_vc_mask_i,
   output logic                                  pkt_ack_o,
   input  logic [FLIT_WIDTH-1:0]                 flit_i,
   input  logic                                  flit_valid_i,
   input  logic                                  flit_tail_i,
   output logic                                  flit_ready_o,
   input  logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_i,
   input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
   output logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_o,
   output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_o,
   output logic [N_TOT_OF_VC-1:0]                release_pointer_o,
   output logic [FLIT_WIDTH-1:0]                 out_link_o,
   output logic                                  is_valid_o,
   output logic [N_TOT_OF_VC-1:0]                out_vc_o,
   output logic                                  credit_overflow_o
);

   localparam int VC_W = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;
   localparam logic [N_BITS_CREDIT-1:0] FULL_CREDIT = N_BITS_CREDIT'(BUFFER_DEPTH);

   typedef enum logic [1:0] {IDLE, ALLOC, SEND} state_t;

   state_t                  state_q;
   logic [VC_W-1:0]         cur_vc_q;
   logic                    is_valid_q;
   logic [FLIT_WIDTH-1:0]   out_link_q;
   logic [N_TOT_OF_VC-1:0]  out_vc_q;
   logic                    overflow_q;

   logic [N_TOT_OF_VC-1:0]  full_credit;
   logic [N_TOT_OF_VC-1:0]  credit_nz;
   logic [N_TOT_OF_VC-1:0]  pending_release;
   logic [N_TOT_OF_VC-1:0]  cur_onehot;
   logic [N_TOT_OF_VC-1:0]  ovf_hit;
   logic [N_TOT_OF_VC-1:0]  cand;
   logic [N_TOT_OF_VC-1:0]  grant;
   logic [N_TOT_OF_VC-1:0]  release_w;
   logic [VC_W-1:0]         grant_idx;
   logic                    transfer;

   // A VC is only handed out when its downstream buffer is completely drained.
   assign cand  = pkt_vc_mask_i & ~fifo_pointer_state_i & ~pending_release & full_credit;
   assign grant = (state_q == ALLOC) ? (cand & (~cand + N_TOT_OF_VC'(1))) : '0;

   always_comb begin
      grant_idx = '0;
      for (int i = N_TOT_OF_VC - 1; i >= 0; i--) begin
         if (cand[i]) grant_idx = VC_W'(i);
      end
   end

   assign pkt_ack_o         = |grant;
   assign g_fifo_pointer_o  = grant;
   assign flit_ready_o      = (state_q == SEND) && (|(credit_nz & cur_onehot));
   assign transfer          = flit_ready_o & flit_valid_i;
   assign release_pointer_o = release_w;
   assign out_link_o        = out_link_q;
   assign is_valid_o        = is_valid_q;
   assign out_vc_o          = out_vc_q;
   assign credit_overflow_o = overflow_q;

   generate
      for (genvar gi = 0; gi < N_TOT_OF_VC; gi++) begin : g_vc
         logic [N_BITS_CREDIT-1:0] credit_q, credit_d;
         logic                     pending_q, pending_d;
         logic                     inc, dec;

         assign cur_onehot[gi]      = (cur_vc_q == VC_W'(gi));
         assign inc                 = credit_signal_i[gi];
         assign dec                 = transfer & cur_onehot[gi];
         assign full_credit[gi]     = (credit_q == FULL_CREDIT);
         assign credit_nz[gi]       = (credit_q != '0);
         assign ovf_hit[gi]         = inc & ~dec & full_credit[gi];
         assign release_w[gi]       = pending_q & full_credit[gi];
         assign pending_release[gi] = pending_q;
         assign g_fifo_out_buffer_id_o[gi*N_BITS_POINTER +: N_BITS_POINTER] =
            grant[gi] ? pkt_buffer_id_i : '0;

         always_comb begin
            credit_d = credit_q;
            if (inc && !dec && !full_credit[gi]) credit_d = credit_q + N_BITS_CREDIT'(1);
            else if (dec && !inc)                credit_d = credit_q - N_BITS_CREDIT'(1);
            pending_d = pending_q;
            if (dec && flit_tail_i)  pending_d = 1'b1;
            else if (release_w[gi])  pending_d = 1'b0;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               credit_q  <= FULL_CREDIT;
               pending_q <= 1'b0;
            end else begin
               credit_q  <= credit_d;
               pending_q <= pending_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cur_vc_q   <= '0;
         is_valid_q <= 1'b0;
         out_link_q <= '0;
         out_vc_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | (|ovf_hit);
         is_valid_q <= transfer;
         out_vc_q   <= transfer ? cur_onehot : '0;
         if (transfer) out_link_q <= flit_i;
         case (state_q)
            IDLE:  if (pkt_req_i) state_q <= ALLOC;
            ALLOC: if (|cand) begin
                      cur_vc_q <= grant_idx;
                      state_q  <= SEND;
                   end
            SEND:  if (transfer && flit_tail_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nic2noc_flit_sender.sv
// Directed bench for nic2noc_flit_sender: inputs change on the falling edge and
// outputs are compared 1 ns later, away from the rising edge.
module tb_nic2noc_flit_sender;

   localparam int NV = 6;
   localparam int NP = 5;
   localparam int FW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              pkt_req_i;
   logic [NP-1:0]     pkt_buffer_id_i;
   logic [NV-1:0]     pkt_vc_mask_i;
   logic              pkt_ack_o;
   logic [FW-1:0]     flit_i;
   logic              flit_valid_i;
   logic              flit_tail_i;
   logic              flit_ready_o;
   logic [NV-1:0]     fifo_pointer_state_i;
   logic [NV-1:0]     credit_signal_i;
   logic [NV-1:0]     g_fifo_pointer_o;
   logic [NV*NP-1:0]  g_fifo_out_buffer_id_o;
   logic [NV-1:0]     release_pointer_o;
   logic [FW-1:0]     out_link_o;
   logic              is_valid_o;
   logic [NV-1:0]     out_vc_o;
   logic              credit_overflow_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nic2noc_flit_sender #(
      .N_TOT_OF_VC(NV), .N_BITS_POINTER(NP), .BUFFER_DEPTH(4),
      .N_BITS_CREDIT(3), .FLIT_WIDTH(FW)
   ) dut (
      .clk(clk), .rst(rst),
      .pkt_req_i(pkt_req_i), .pkt_buffer_id_i(pkt_buffer_id_i),
      .pkt_vc_mask_i(pkt_vc_mask_i), .pkt_ack_o(pkt_ack_o),
      .flit_i(flit_i), .flit_valid_i(flit_valid_i), .flit_tail_i(flit_tail_i),
      .flit_ready_o(flit_ready_o), .fifo_pointer_state_i(fifo_pointer_state_i),
      .credit_signal_i(credit_signal_i), .g_fifo_pointer_o(g_fifo_pointer_o),
      .g_fifo_out_buffer_id_o(g_fifo_out_buffer_id_o),
      .release_pointer_o(release_pointer_o), .out_link_o(out_link_o),
      .is_valid_o(is_valid_o), .out_vc_o(out_vc_o),
      .credit_overflow_o(credit_overflow_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; pkt_req_i = 0; pkt_buffer_id_i = '0; pkt_vc_mask_i = '0;
      flit_i = '0; flit_valid_i = 0; flit_tail_i = 0;
      fifo_pointer_state_i = '0; credit_signal_i = '0;
      tick(); tick();
      #1;
      chk("rst_ack", 64'(pkt_ack_o), 64'd0);
      chk("rst_grant", 64'(g_fifo_pointer_o), 64'd0);
      chk("rst_valid", 64'(is_valid_o), 64'd0);
      chk("rst_link", 64'(out_link_o), 64'd0);
      chk("rst_ovf", 64'(credit_overflow_o), 64'd0);
      chk("rst_ready", 64'(flit_ready_o), 64'd0);
      chk("rst_release", 64'(release_pointer_o), 64'd0);
      tick();
      rst = 1'b1;

      // Packet A: 3 flits on VC2
      pkt_req_i = 1; pkt_buffer_id_i = 5'd3; pkt_vc_mask_i = 6'b001100;
      #1 chk("a_idle_grant", 64'(g_fifo_pointer_o), 64'd0);
      tick(); #1;
      chk("a_grant", 64'(g_fifo_pointer_o), 64'b000100);
      chk("a_ack", 64'(pkt_ack_o), 64'd1);
      chk("a_bufid", 64'(g_fifo_out_buffer_id_o), 64'd3 << 10);
      tick();
      pkt_req_i = 0; flit_valid_i = 1; flit_i = 16'hA001;
      #1 chk("a_ack_gone", 64'(pkt_ack_o), 64'd0);
      chk("a_ready", 64'(flit_ready_o), 64'd1);
      tick();
      flit_i = 16'hA002;
      #1 chk("a_valid1", 64'(is_valid_o), 64'd1);
      chk("a_link1", 64'(out_link_o), 64'hA001);
      chk("a_vc1", 64'(out_vc_o), 64'b000100);
      tick();
      flit_i = 16'hA003; flit_tail_i = 1;
      #1 chk("a_link2", 64'(out_link_o), 64'hA002);
      tick();
      flit_valid_i = 0; flit_tail_i = 0;
      #1 chk("a_link3", 64'(out_link_o), 64'hA003);
      chk("a_valid3", 64'(is_valid_o), 64'd1);
      chk("a_ready_idle", 64'(flit_ready_o), 64'd0);
      tick();
      credit_signal_i = 6'b000100;
      #1 chk("a_valid_off", 64'(is_valid_o), 64'd0);
      chk("a_vc_off", 64'(out_vc_o), 64'd0);
      tick();
      #1 chk("a_rel_early1", 64'(release_pointer_o), 64'd0);
      tick();
      #1 chk("a_rel_early2", 64'(release_pointer_o), 64'd0);
      tick();
      credit_signal_i = '0;
      #1 chk("a_release", 64'(release_pointer_o), 64'b000100);
      tick();
      #1 chk("a_release_once", 64'(release_pointer_o), 64'd0);

      // Packet B: stalls in ALLOC, then 6 flits on VC0 under credit control
      pkt_req_i = 1; pkt_buffer_id_i = 5'd7; pkt_vc_mask_i = 6'b000011;
      fifo_pointer_state_i = 6'b000011;
      tick();
      #1 chk("b_stall_grant", 64'(g_fifo_pointer_o), 64'd0);
      chk("b_stall_ack", 64'(pkt_ack_o), 64'd0);
      tick();
      #1 chk("b_stall_grant2", 64'(g_fifo_pointer_o), 64'd0);
      fifo_pointer_state_i = 6'b000010;
      #1 chk("b_grant", 64'(g_fifo_pointer_o), 64'b000001);
      chk("b_bufid", 64'(g_fifo_out_buffer_id_o), 64'd7);
      tick();
      pkt_req_i = 0; fifo_pointer_state_i = '0; flit_valid_i = 1;
      for (int i = 0; i < 4; i++) begin
         flit_i = 16'hB001 + 16'(i);
         #1 chk("b_ready_full", 64'(flit_ready_o), 64'd1);
         tick();
      end
      flit_i = 16'hB005;
      #1 chk("b_ready_empty", 64'(flit_ready_o), 64'd0);
      tick();
      credit_signal_i = 6'b000001;
      #1 chk("b_ready_empty2", 64'(flit_ready_o), 64'd0);
      tick();
      credit_signal_i = '0;
      #1 chk("b_ready_credit1", 64'(flit_ready_o), 64'd1);
      tick();
      #1 chk("b_ready_after5", 64'(flit_ready_o), 64'd0);
      chk("b_link5", 64'(out_link_o), 64'hB005);
      tick();
      credit_signal_i = 6'b000001;
      tick();
      credit_signal_i = '0; flit_i = 16'hB006; flit_tail_i = 1;
      #1 chk("b_ready_credit2", 64'(flit_ready_o), 64'd1);
      tick();
      flit_valid_i = 0; flit_tail_i = 0;
      #1 chk("b_link6", 64'(out_link_o), 64'hB006);
      chk("b_vc6", 64'(out_vc_o), 64'b000001);

      // Packet C on VC1 while VC0 drains; simultaneous credit+send on VC1 at credit 2
      pkt_req_i = 1; pkt_buffer_id_i = 5'd9; pkt_vc_mask_i = 6'b000011;
      tick();
      #1 chk("c_grant_skip_vc0", 64'(g_fifo_pointer_o), 64'b000010);
      chk("c_bufid", 64'(g_fifo_out_buffer_id_o), 64'd9 << 5);
      tick();
      pkt_req_i = 0; flit_valid_i = 1; flit_i = 16'hC001; credit_signal_i = 6'b000001;
      tick();
      flit_i = 16'hC002;
      tick();
      flit_i = 16'hC003; credit_signal_i = 6'b000011;
      #1 chk("c_link2", 64'(out_link_o), 64'hC002);
      tick();
      flit_i = 16'hC004; credit_signal_i = 6'b000001;
      #1 chk("c_rel_early", 64'(release_pointer_o), 64'd0);
      tick();
      flit_i = 16'hC005; credit_signal_i = '0;
      #1 chk("c_release_vc0", 64'(release_pointer_o), 64'b000001);
      chk("c_ready_cr1", 64'(flit_ready_o), 64'd1);
      tick();
      #1 chk("c_release_done", 64'(release_pointer_o), 64'd0);
      chk("c_ready_cr0", 64'(flit_ready_o), 64'd0);
      flit_i = 16'hC006; flit_tail_i = 1; credit_signal_i = 6'b000010;
      tick();
      credit_signal_i = '0;
      #1 chk("c_ready_tail", 64'(flit_ready_o), 64'd1);
      tick();
      flit_valid_i = 0; flit_tail_i = 0;
      #1 chk("c_vc6", 64'(out_vc_o), 64'b000010);
      chk("c_link6", 64'(out_link_o), 64'hC006);

      // Overflow: extra credit on full VC2
      credit_signal_i = 6'b000100;
      #1 chk("ovf_before", 64'(credit_overflow_o), 64'd0);
      tick();
      credit_signal_i = '0;
      #1 chk("ovf_set", 64'(credit_overflow_o), 64'd1);
      tick();
      #1 chk("ovf_sticky", 64'(credit_overflow_o), 64'd1);
      chk("ovf_no_release", 64'(release_pointer_o), 64'd0);

      // Reset mid-packet on VC5
      pkt_req_i = 1; pkt_buffer_id_i = 5'd5; pkt_vc_mask_i = 6'b100000;
      tick();
      #1 chk("d_grant", 64'(g_fifo_pointer_o), 64'b100000);
      tick();
      pkt_req_i = 0; flit_valid_i = 1; flit_i = 16'hD001;
      tick();
      flit_valid_i = 0;
      #1 chk("d_valid", 64'(is_valid_o), 64'd1);
      rst = 1'b0;
      #1 chk("d_rst_valid", 64'(is_valid_o), 64'd0);
      chk("d_rst_link", 64'(out_link_o), 64'd0);
      chk("d_rst_vc", 64'(out_vc_o), 64'd0);
      chk("d_rst_ovf", 64'(credit_overflow_o), 64'd0);
      chk("d_rst_ready", 64'(flit_ready_o), 64'd0);
      tick(); tick();
      rst = 1'b1;
      pkt_req_i = 1; pkt_buffer_id_i = 5'd2; pkt_vc_mask_i = 6'b100010;
      tick();
      #1 chk("e_grant_vc1", 64'(g_fifo_pointer_o), 64'b000010);
      chk("e_release", 64'(release_pointer_o), 64'd0);
      tick();
      pkt_req_i = 0; flit_valid_i = 1;
      for (int i = 0; i < 4; i++) begin
         flit_i = 16'hE001 + 16'(i);
         #1 chk("e_ready_full", 64'(flit_ready_o), 64'd1);
         tick();
      end
      #1 chk("e_ready_empty", 64'(flit_ready_o), 64'd0);
      flit_valid_i = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
